// File: rtl/serial_comparator_pkg.sv
// rtl/serial_comparator_pkg.sv - shared state/result encodings for the serial comparator
package serial_comparator_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1
  } state_t;

  typedef enum logic [1:0] {
    RES_EQ  = 2'd0,
    RES_AGT = 2'd1,
    RES_BGT = 2'd2
  } result_t;

  // No recorded difference means the operands matched on every bit.
  function automatic result_t resolve(input logic decided, input logic a_wins);
    if (!decided) return RES_EQ;
    return a_wins ? RES_AGT : RES_BGT;
  endfunction

endpackage

// File: rtl/serial_comparator_cmp_bit_step.sv
// rtl/serial_comparator_cmp_bit_step.sv - single-bit compare cell, sign-aware at the MSB
module cmp_bit_step (
  input  logic a_bit,
  input  logic b_bit,
  input  logic is_msb,
  input  logic signed_mode,
  output logic differ,
  output logic a_wins
);

  // In two's complement a 0 in the sign bit is the larger value.
  assign differ = a_bit ^ b_bit;
  assign a_wins = (is_msb && signed_mode) ? ~a_bit : a_bit;

endmodule

// File: rtl/serial_comparator.sv
// rtl/serial_comparator.sv - bit-serial MSB-first magnitude comparator with start/busy/done
module serial_comparator
  import serial_comparator_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic             gtA,
  output logic             gtB,
  output logic             AeqB
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IDX_W-1:0] IDX_MSB = IDX_W'(WIDTH - 1);

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_signed;
  logic [IDX_W-1:0] r_idx;
  logic             r_diff;
  logic             r_a_wins;
  logic             r_busy;
  logic             r_done;
  logic             r_gta;
  logic             r_gtb;
  logic             r_eq;

  logic    w_is_msb;
  logic    w_differ;
  logic    w_a_wins;
  logic    w_first_diff;
  logic    w_last;
  logic    w_decided;
  logic    w_final_a_wins;
  result_t w_result;

  assign w_is_msb = (r_idx == IDX_MSB);

  cmp_bit_step u_step (
    .a_bit       (r_a[r_idx]),
    .b_bit       (r_b[r_idx]),
    .is_msb      (w_is_msb),
    .signed_mode (r_signed),
    .differ      (w_differ),
    .a_wins      (w_a_wins)
  );

  // Only the first difference decides; later bits are examined but ignored.
  assign w_first_diff   = w_differ && !r_diff;
  assign w_last         = (r_idx == '0) || (EARLY_EXIT && w_first_diff);
  assign w_decided      = r_diff || w_first_diff;
  assign w_final_a_wins = r_diff ? r_a_wins : w_a_wins;
  assign w_result       = resolve(w_decided, w_final_a_wins);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_signed <= 1'b0;
      r_idx    <= '0;
      r_diff   <= 1'b0;
      r_a_wins <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_gta    <= 1'b0;
      r_gtb    <= 1'b0;
      r_eq     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_a      <= A;
            r_b      <= B;
            r_signed <= signed_mode;
            r_idx    <= IDX_MSB;
            r_diff   <= 1'b0;
            r_a_wins <= 1'b0;
            r_gta    <= 1'b0;
            r_gtb    <= 1'b0;
            r_eq     <= 1'b0;
            r_busy   <= 1'b1;
            r_state  <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (w_first_diff) begin
            r_diff   <= 1'b1;
            r_a_wins <= w_a_wins;
          end
          if (w_last) begin
            r_gta   <= (w_result == RES_AGT);
            r_gtb   <= (w_result == RES_BGT);
            r_eq    <= (w_result == RES_EQ);
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end else begin
            r_idx <= r_idx - IDX_W'(1);
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign gtA  = r_gta;
  assign gtB  = r_gtb;
  assign AeqB = r_eq;

endmodule

// File: tb/tb_serial_comparator.sv
// tb/tb_serial_comparator.sv - randomized and directed checks of serial_comparator against a behavioural model
module tb_serial_comparator;

  logic       clk;
  logic       rst_n;
  logic       sm_bus;
  logic [7:0] a_bus;
  logic [7:0] b_bus;
  logic       start_v [3];
  logic       busy_v  [3];
  logic       done_v  [3];
  logic       gta_v   [3];
  logic       gtb_v   [3];
  logic       eq_v    [3];

  int n_checks;
  int n_fail;

  // Instance geometry: 0 = 4-bit early-exit, 1 = 4-bit constant-time, 2 = 8-bit constant-time.
  int inst_w  [3] = '{4, 4, 8};
  int inst_ee [3] = '{1, 0, 0};

  serial_comparator #(.WIDTH(4), .EARLY_EXIT(1'b1)) dut_e4 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .signed_mode(sm_bus),
    .A(a_bus[3:0]), .B(b_bus[3:0]), .busy(busy_v[0]), .done(done_v[0]),
    .gtA(gta_v[0]), .gtB(gtb_v[0]), .AeqB(eq_v[0])
  );

  serial_comparator #(.WIDTH(4), .EARLY_EXIT(1'b0)) dut_c4 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .signed_mode(sm_bus),
    .A(a_bus[3:0]), .B(b_bus[3:0]), .busy(busy_v[1]), .done(done_v[1]),
    .gtA(gta_v[1]), .gtB(gtb_v[1]), .AeqB(eq_v[1])
  );

  serial_comparator #(.WIDTH(8), .EARLY_EXIT(1'b0)) dut_c8 (
    .clk(clk), .rst_n(rst_n), .start(start_v[2]), .signed_mode(sm_bus),
    .A(a_bus), .B(b_bus), .busy(busy_v[2]), .done(done_v[2]),
    .gtA(gta_v[2]), .gtB(gtb_v[2]), .AeqB(eq_v[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 0 = equal, 1 = A greater, 2 = B greater, from the numeric values of the operands.
  function automatic int model_result(input int w, input int a, input int b, input bit sm);
    int mask;
    int va;
    int vb;
    mask = (1 << w) - 1;
    va = a & mask;
    vb = b & mask;
    if (sm && va >= (1 << (w - 1))) va = va - (1 << w);
    if (sm && vb >= (1 << (w - 1))) vb = vb - (1 << w);
    if (va > vb) return 1;
    if (vb > va) return 2;
    return 0;
  endfunction

  function automatic int model_latency(input int w, input int ee, input int a, input int b);
    int x;
    int p;
    x = (a ^ b) & ((1 << w) - 1);
    if (ee == 0 || x == 0) return w;
    p = 0;
    for (int i = 0; i < w; i++) if ((x >> i) & 1) p = i;
    return w - p;
  endfunction

  // Issues start from the current cycle (so it may sit in a done cycle), then waits for done.
  task automatic run_cmp(input int k, input int a, input int b, input bit sm, input bit scramble);
    int lat;
    int exp_lat;
    int exp_res;
    exp_lat = model_latency(inst_w[k], inst_ee[k], a, b);
    exp_res = model_result(inst_w[k], a, b, sm);
    a_bus = a[7:0];
    b_bus = b[7:0];
    sm_bus = sm;
    start_v[k] = 1'b1;
    @(posedge clk);
    #1;
    start_v[k] = 1'b0;
    n_checks++;
    if (busy_v[k] !== 1'b1 || done_v[k] !== 1'b0 || gta_v[k] !== 1'b0 ||
        gtb_v[k] !== 1'b0 || eq_v[k] !== 1'b0) begin
      n_fail++;
      $display("FAIL accept_clear inst%0d: busy=%b done=%b gtA=%b gtB=%b eq=%b, required busy=1 others 0",
               k, busy_v[k], done_v[k], gta_v[k], gtb_v[k], eq_v[k]);
    end
    lat = 0;
    while (done_v[k] !== 1'b1 && lat < 40) begin
      if (scramble) begin
        a_bus = 8'($urandom);
        b_bus = 8'($urandom);
        sm_bus = 1'($urandom);
      end
      @(posedge clk);
      #1;
      lat++;
    end
    n_checks++;
    if (lat != exp_lat) begin
      n_fail++;
      $display("FAIL latency inst%0d a=%0h b=%0h sm=%0d: got %0d edges, required %0d", k, a, b, sm, lat, exp_lat);
    end
    n_checks++;
    if (busy_v[k] !== 1'b0 || gta_v[k] !== (exp_res == 1) || gtb_v[k] !== (exp_res == 2) ||
        eq_v[k] !== (exp_res == 0)) begin
      n_fail++;
      $display("FAIL result inst%0d a=%0h b=%0h sm=%0d: busy=%b gtA=%b gtB=%b eq=%b, required busy=0 code %0d",
               k, a, b, sm, busy_v[k], gta_v[k], gtb_v[k], eq_v[k], exp_res);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if ({busy_v[k], done_v[k], gta_v[k], gtb_v[k], eq_v[k]} !== 5'b0) begin
        n_fail++;
        $display("FAIL reset inst%0d: outputs=%b, required 00000", k,
                 {busy_v[k], done_v[k], gta_v[k], gtb_v[k], eq_v[k]});
      end
    end
  endtask

  task automatic test_directed();
    run_cmp(0, 4'b0001, 4'b0100, 1'b0, 1'b0);
    run_cmp(0, 4'b0101, 4'b0100, 1'b0, 1'b0);
    run_cmp(0, 4'b1001, 4'b0110, 1'b0, 1'b0);
    run_cmp(0, 4'b1001, 4'b0110, 1'b1, 1'b0);
    run_cmp(1, 4'b1001, 4'b0110, 1'b0, 1'b0);
    run_cmp(2, 8'h80, 8'h7F, 1'b1, 1'b0);
  endtask

  task automatic test_hold();
    run_cmp(0, 4'b1001, 4'b1001, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      n_checks++;
      if (eq_v[0] !== 1'b1 || gta_v[0] !== 1'b0 || gtb_v[0] !== 1'b0 || done_v[0] !== 1'b0) begin
        n_fail++;
        $display("FAIL hold cycle%0d: eq=%b gtA=%b gtB=%b done=%b, required eq=1 others 0",
                 i, eq_v[0], gta_v[0], gtb_v[0], done_v[0]);
      end
    end
    run_cmp(0, 4'b0011, 4'b0010, 1'b0, 1'b0);
  endtask

  task automatic test_busy_ignore();
    int lat;
    a_bus = 8'h09;
    b_bus = 8'h06;
    sm_bus = 1'b0;
    start_v[1] = 1'b1;
    @(posedge clk);
    #1;
    start_v[1] = 1'b0;
    @(posedge clk);
    #1;
    a_bus = 8'h00;
    b_bus = 8'h0F;
    sm_bus = 1'b1;
    start_v[1] = 1'b1;
    @(posedge clk);
    #1;
    start_v[1] = 1'b0;
    lat = 2;
    while (done_v[1] !== 1'b1 && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    n_checks++;
    if (lat != 4 || gta_v[1] !== 1'b1 || gtb_v[1] !== 1'b0 || eq_v[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_ignore: lat=%0d gtA=%b gtB=%b eq=%b, required lat=4 gtA=1", lat, gta_v[1], gtb_v[1], eq_v[1]);
    end
  endtask

  task automatic test_back_to_back();
    run_cmp(0, 4'b0110, 4'b0111, 1'b0, 1'b0);
    run_cmp(0, 4'b1111, 4'b0000, 1'b1, 1'b0);
    run_cmp(0, 4'b1000, 4'b1000, 1'b1, 1'b0);
    run_cmp(2, 8'h3C, 8'h3D, 1'b0, 1'b0);
    run_cmp(2, 8'hFF, 8'h01, 1'b1, 1'b0);
  endtask

  task automatic test_reset_mid();
    int seen_done;
    a_bus = 8'h80;
    b_bus = 8'h7F;
    sm_bus = 1'b1;
    start_v[2] = 1'b1;
    @(posedge clk);
    #1;
    start_v[2] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    n_checks++;
    if ({busy_v[2], done_v[2], gta_v[2], gtb_v[2], eq_v[2]} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_mid: outputs=%b, required 00000", {busy_v[2], done_v[2], gta_v[2], gtb_v[2], eq_v[2]});
    end
    seen_done = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (done_v[2] === 1'b1 || busy_v[2] === 1'b1) seen_done++;
    end
    n_checks++;
    if (seen_done != 0) begin
      n_fail++;
      $display("FAIL reset_abort: %0d cycles with busy/done after reset, required 0", seen_done);
    end
    run_cmp(0, 4'b0101, 4'b0100, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      run_cmp(int'($urandom_range(0, 2)), int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
              1'($urandom), 1'b1);
      if ($urandom_range(0, 1) == 1) begin
        @(posedge clk);
        #1;
      end
    end
    for (int i = 0; i < 6; i++) begin
      int v;
      v = int'($urandom_range(0, 255));
      run_cmp(i % 3, v, v, 1'($urandom), 1'b1);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    rst_n = 1'b0;
    sm_bus = 1'b0;
    a_bus = '0;
    b_bus = '0;
    for (int k = 0; k < 3; k++) start_v[k] = 1'b0;
    @(negedge clk);
    test_reset();
    test_directed();
    test_hold();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
